palette_ram_ctrl: RTL

- Owns a 64x15-bit custom palette RAM and shares its single port between two requesters: the pixel-lookup path in the video block and a host byte-stream palette downloader.
- Video reads always win the port. Downloaded RGB888 triplets are packed to 15-bit BGR555, queued in a small FIFO and committed only in cycles with no video read.
- Sequences the download lifecycle and reports when a complete custom palette is valid, so the video block can switch from its built-in LUTs to the custom palette.

---
 rtl/pal_pkg.sv | 30 +++
 rtl/pal_wr_fifo.sv | 54 +++++
 rtl/palette_ram_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pal_pkg.sv
// Shared types for the custom palette RAM controller.
// Pixel format is BGR555: {B[4:0],G[4:0],R[4:0]}.
package pal_pkg;

   localparam int PAL_ENTRIES = 64;
   localparam int PAL_IDX_W   = 6;
   localparam int PAL_PIX_W   = 15;

   typedef logic [PAL_PIX_W-1:0] pal_pix_t;

   typedef struct packed {
      logic [PAL_IDX_W-1:0] idx;
      pal_pix_t             pix;
   } pal_wr_t;

   typedef enum logic [1:0] {
      IDLE,
      LOADING,
      DRAIN
   } dl_state_t;

   function automatic pal_pix_t pack_bgr555(
      input logic [4:0] r5,
      input logic [4:0] g5,
      input logic [4:0] b5
   );
      return {b5, g5, r5};
   endfunction

endpackage

// File: rtl/pal_wr_fifo.sv
// Small synchronous FIFO of pending palette writes.
// Push when full and pop when empty are ignored; flush wins over both.
module pal_wr_fifo
   import pal_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  pal_wr_t       din,
   input  logic          pop,
   input  logic          flush,
   output pal_wr_t       dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   pal_wr_t       mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rp];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop)  rp <= rp + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end

endmodule

// File: rtl/palette_ram_ctrl.sv
// Custom palette RAM: video reads own the port, downloaded RGB888
// triplets are packed to BGR555 and committed in read-free cycles.
module palette_ram_ctrl
   import pal_pkg::*;
#(
   parameter  int ENTRIES    = PAL_ENTRIES,
   parameter  int FIFO_DEPTH = 4,
   localparam int IW         = $clog2(ENTRIES),
   localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          dl_start,
   input  logic          dl_end,
   input  logic          dl_wr,
   input  logic [7:0]    dl_data,
   output logic          dl_wait,
   input  logic          rd_req,
   input  logic [IW-1:0] rd_idx,
   output pal_pix_t      rd_data,
   output logic          rd_valid,
   output logic          pal_loaded,
   output logic          busy,
   output logic          overflow
);

   dl_state_t     state;
   dl_state_t     state_n;
   logic [IW:0]   idx;
   logic [1:0]    phase;
   logic [4:0]    r5;
   logic [4:0]    g5;
   logic          idx_end;
   logic          start_dl;
   logic          flush;
   logic          accepting;
   logic          end_dl;
   logic          finish;
   logic          accept;
   logic          push;
   logic          pop;
   logic          we;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   pal_wr_t       wr_in;
   pal_wr_t       head;
   logic [IW-1:0] addr;
   pal_pix_t      mem [ENTRIES];
   logic          unused_bits;

   assign unused_bits = ^dl_data[2:0];

   assign idx_end = (idx == (IW+1)'(ENTRIES));
   assign busy    = (state != IDLE);
   assign dl_wait = full && (state != DRAIN);
   assign accept  = accepting && dl_wr && !dl_wait;
   assign push    = accept && (phase == 2'd2) && !idx_end;

   assign wr_in.idx = PAL_IDX_W'(idx[IW-1:0]);
   assign wr_in.pix = pack_bgr555(r5, g5, dl_data[7:3]);

   pal_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (wr_in),
      .pop   (pop),
      .flush (flush),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      start_dl  = 1'b0;
      flush     = 1'b0;
      accepting = 1'b0;
      end_dl    = 1'b0;
      finish    = 1'b0;
      unique case (state)
         IDLE: begin
            if (dl_start) begin
               start_dl = 1'b1;
               state_n  = LOADING;
            end
         end
         LOADING: begin
            if (dl_start) begin
               start_dl = 1'b1;
               flush    = 1'b1;
            end else begin
               accepting = 1'b1;
               if (dl_end) begin
                  end_dl  = 1'b1;
                  state_n = DRAIN;
               end
            end
         end
         DRAIN: begin
            // nothing is pushed in DRAIN, so an empty queue means done
            if (count == '0) begin
               finish  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx        <= '0;
         phase      <= '0;
         r5         <= '0;
         g5         <= '0;
         overflow   <= 1'b0;
         pal_loaded <= 1'b0;
      end else begin
         if (start_dl) begin
            idx        <= '0;
            phase      <= '0;
            overflow   <= 1'b0;
            pal_loaded <= 1'b0;
         end else if (accept) begin
            if (idx_end) begin
               overflow <= 1'b1;
            end else begin
               unique case (phase)
                  2'd0: begin
                     r5    <= dl_data[7:3];
                     phase <= 2'd1;
                  end
                  2'd1: begin
                     g5    <= dl_data[7:3];
                     phase <= 2'd2;
                  end
                  default: begin
                     phase <= 2'd0;
                     idx   <= idx + (IW+1)'(1);
                  end
               endcase
            end
         end
         // a trailing partial triplet is dropped here
         if (end_dl) phase <= 2'd0;
         if (finish) pal_loaded <= idx_end;
      end
   end

   assign pop  = !rd_req && !empty;
   assign we   = pop && !reset;
   assign addr = rd_req ? rd_idx : IW'(head.idx);

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= head.pix;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) rd_data <= mem[addr];
      end
   end

endmodule
